// File: rtl/fpu_pkg.sv
// Shared widths and the alignment pipeline register type for the FPU add/sub front end.
package fpu_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned MANT_X_W = 27;

  typedef struct packed {
    logic                sign;
    logic [EXP_W-1:0]    exp;
    logic [MANT_X_W-1:0] mant_l;
    logic [MANT_X_W-1:0] mant_s;
    logic                eff_sub;
    logic                special;
  } align_t;

endpackage

// File: rtl/fpu_shift_sticky.sv
// Combinational right shifter for extended significands; shifted-out bits collapse into bit 0 (sticky).
module fpu_shift_sticky
  import fpu_pkg::*;
(
  input  logic [MANT_X_W-1:0] mant_in,
  input  logic [EXP_W-1:0]    shamt,
  output logic [MANT_X_W-1:0] mant_out
);

  logic [MANT_X_W-1:0] mask;
  logic                sticky;

  always_comb begin
    mask     = '0;
    sticky   = 1'b0;
    mant_out = '0;
    if (shamt >= EXP_W'(MANT_X_W)) begin
      mant_out = {{(MANT_X_W-1){1'b0}}, |mant_in};
    end else begin
      // Amounts below 27 fit in 5 bits; mask selects exactly the bits shifted out.
      mask     = (MANT_X_W'(1) << shamt[4:0]) - MANT_X_W'(1);
      sticky   = |(mant_in & mask);
      mant_out = (mant_in >> shamt[4:0]) | {{(MANT_X_W-1){1'b0}}, sticky};
    end
  end

endmodule

// File: rtl/fpu_align_stage.sv
// Registered operand-alignment stage ahead of the FPU adder: flush, order, shift, valid/ready handshake.
// Optional exponent-255 flag enabled by defining FPU_ALIGN_SPECIAL_EN.
module fpu_align_stage
  import fpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         x1,
  input  logic [31:0]         x2,
  input  logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sign,
  output logic [EXP_W-1:0]    out_exp,
  output logic [MANT_X_W-1:0] out_mant_l,
  output logic [MANT_X_W-1:0] out_mant_s,
  output logic                out_eff_sub,
  output logic                out_special
);

  logic                s1, s2, sl, swap, special;
  logic [EXP_W-1:0]    e1, e2, el, es, d;
  logic [MANT_X_W-1:0] m1, m2, ml, ms, ms_al;
  align_t              nxt, r;

  always_comb begin
    s1   = x1[31];
    s2   = x2[31] ^ op_sub;
    e1   = x1[30:23];
    e2   = x2[30:23];
    m1   = (e1 == '0) ? '0 : {1'b1, x1[FRAC_W-1:0], 3'b000};
    m2   = (e2 == '0) ? '0 : {1'b1, x2[FRAC_W-1:0], 3'b000};
    // Magnitude order from the raw exponent/fraction bits; ties keep x1 as the larger.
    swap = x1[30:0] < x2[30:0];
    sl   = swap ? s2 : s1;
    el   = swap ? e2 : e1;
    es   = swap ? e1 : e2;
    ml   = swap ? m2 : m1;
    ms   = swap ? m1 : m2;
    d    = el - es;
  end

  fpu_shift_sticky u_shift (
    .mant_in  (ms),
    .shamt    (d),
    .mant_out (ms_al)
  );

`ifdef FPU_ALIGN_SPECIAL_EN
  assign special = (e1 == '1) | (e2 == '1);
`else
  assign special = 1'b0;
`endif

  always_comb begin
    nxt         = '0;
    nxt.sign    = sl;
    nxt.exp     = el;
    nxt.mant_l  = ml;
    nxt.mant_s  = ms_al;
    nxt.eff_sub = s1 ^ s2;
    nxt.special = special;
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      r         <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) r <= nxt;
    end
  end

  assign out_sign    = r.sign;
  assign out_exp     = r.exp;
  assign out_mant_l  = r.mant_l;
  assign out_mant_s  = r.mant_s;
  assign out_eff_sub = r.eff_sub;
  assign out_special = r.special;

endmodule

// File: tb/tb_fpu_align_stage.sv
// Scoreboard bench for fpu_align_stage: directed test-plan vectors, backpressure, reset mid-stall, random traffic.
module tb_fpu_align_stage;
  import fpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid, in_ready;
  logic [31:0]         x1, x2;
  logic                op_sub;
  logic                out_valid, out_ready;
  logic                out_sign, out_eff_sub, out_special;
  logic [EXP_W-1:0]    out_exp;
  logic [MANT_X_W-1:0] out_mant_l, out_mant_s;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  align_t      sb[$];

  always #5 clk = ~clk;

  fpu_align_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x1          (x1),
    .x2          (x2),
    .op_sub      (op_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_exp     (out_exp),
    .out_mant_l  (out_mant_l),
    .out_mant_s  (out_mant_s),
    .out_eff_sub (out_eff_sub),
    .out_special (out_special)
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: bitwise magnitude decision and a one-bit-at-a-time shift collecting sticky.
  function automatic align_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    align_t      t;
    logic        sa, sb_, a_big, st;
    logic [7:0]  ea, eb, d;
    logic [26:0] ma, mb, m;
    sa  = a[31];
    sb_ = b[31] ^ sub;
    ea  = a[30:23];
    eb  = b[30:23];
    ma  = (ea == 8'd0) ? 27'd0 : {1'b1, a[22:0], 3'b000};
    mb  = (eb == 8'd0) ? 27'd0 : {1'b1, b[22:0], 3'b000};
    if (ea != eb) a_big = ea > eb;
    else          a_big = a[22:0] >= b[22:0];
    t = '0;
    t.sign    = a_big ? sa : sb_;
    t.exp     = a_big ? ea : eb;
    t.mant_l  = a_big ? ma : mb;
    t.eff_sub = sa ^ sb_;
    m  = a_big ? mb : ma;
    d  = a_big ? (ea - eb) : (eb - ea);
    st = 1'b0;
    for (int i = 0; i < int'(d); i++) begin
      st = st | m[0];
      m  = m >> 1;
    end
    m[0] = m[0] | st;
    t.mant_s = m;
`ifdef FPU_ALIGN_SPECIAL_EN
    t.special = (ea == 8'hFF) || (eb == 8'hFF);
`endif
    return t;
  endfunction

  function automatic align_t observed();
    align_t t;
    t.sign = out_sign; t.exp = out_exp; t.mant_l = out_mant_l;
    t.mant_s = out_mant_s; t.eff_sub = out_eff_sub; t.special = out_special;
    return t;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_nonempty", 72'(sb.size()), 72'd1);
        else chk("sb_result", 72'(observed()), 72'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back(model(x1, x2, op_sub));
    end
  end

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    case ($urandom_range(0, 7))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3:    e = 8'(120 + $urandom_range(0, 20));
      default: e = 8'($urandom);
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                     input logic [7:0] e_exp, input logic e_sign, input logic e_eff,
                     input logic [26:0] e_l, input logic [26:0] e_s);
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; x1 = a; x2 = b; op_sub = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_valid"}, 72'(out_valid), 72'd1);
    chk({tag, "_exp"}, 72'(out_exp), 72'(e_exp));
    chk({tag, "_sign"}, 72'(out_sign), 72'(e_sign));
    chk({tag, "_effsub"}, 72'(out_eff_sub), 72'(e_eff));
    chk({tag, "_mant_l"}, 72'(out_mant_l), 72'(e_l));
    chk({tag, "_mant_s"}, 72'(out_mant_s), 72'(e_s));
  endtask

  initial begin
    align_t held;
    logic   exp_special;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x1 = '0; x2 = '0; op_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 72'(out_valid), 72'd0);
    chk("rst_ready", 72'(in_ready), 72'd1);
    chk("rst_data", 72'(observed()), 72'd0);
    rst = 1'b0;

    dir("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 8'd127, 1'b0, 1'b1, 27'h4000000, 27'h4000000);
    dir("swap", 32'h3F800000, 32'h40000000, 1'b1, 8'd128, 1'b1, 1'b1, 27'h4000000, 27'h2000000);
    dir("sticky", 32'h4B000000, 32'h3F800001, 1'b0, 8'd150, 1'b0, 1'b0, 27'h4000000, 27'h0000009);
    dir("big_shift", 32'h64000000, 32'h3F800000, 1'b0, 8'd200, 1'b0, 1'b0, 27'h4000000, 27'h0000001);
    dir("denorm", 32'h64000000, 32'h00400000, 1'b0, 8'd200, 1'b0, 1'b0, 27'h4000000, 27'h0000000);
    dir("inf", 32'h7F800000, 32'h3F800000, 1'b0, 8'd255, 1'b0, 1'b0, 27'h4000000, 27'h0000001);
`ifdef FPU_ALIGN_SPECIAL_EN
    exp_special = 1'b1;
`else
    exp_special = 1'b0;
`endif
    chk("special", 72'(out_special), 72'(exp_special));

    // Backpressure: A captured, B offered while stalled for 3 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; x1 = 32'h3F800000; x2 = 32'h40000000; op_sub = 1'b1;
    @(posedge clk); #1;
    held = observed();
    x1 = 32'h4B000000; x2 = 32'h3F800001; op_sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", 72'(in_ready), 72'd0);
      chk("stall_valid", 72'(out_valid), 72'd1);
      chk("stall_hold", 72'(observed()), 72'(held));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 72'(in_ready), 72'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release_valid", 72'(out_valid), 72'd1);
    chk("release_mant_s", 72'(out_mant_s), 72'h9);
    chk("release_exp", 72'(out_exp), 72'd150);

    // Reset while stalled discards the held result immediately.
    out_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_stall_valid", 72'(out_valid), 72'd0);
    chk("rst_stall_data", 72'(observed()), 72'd0);
    chk("rst_stall_ready", 72'(in_ready), 72'd1);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      x1 = rnd_op();
      x2 = ($urandom_range(0, 7) == 0) ? x1 : rnd_op();
      op_sub = 1'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 72'(sb.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
